// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, datapath widths, FSM state and buffer entry types for the execute stage.
package alu_pkg;
  localparam int DATA_W = 32;
  localparam int TAG_W = 5;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_XOR = 4'b1100;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic zero;
    logic illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;
endpackage

// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: input and output valid/ready channels of the execute stage.
interface alu_exec_stage_if;
  import alu_pkg::*;
  logic in_valid;
  logic in_ready;
  logic [3:0] in_op;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_result;
  logic out_zero;
  logic out_illegal;
  logic [TAG_W-1:0] out_tag;
  modport slave (
    input in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_illegal, out_tag
  );
  modport master (
    output in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input in_ready, out_valid, out_result, out_zero, out_illegal, out_tag
  );
endinterface

// File: rtl/alu_core.sv
// alu_core: combinational ALU; unsupported op codes yield result 0 with the illegal flag set.
module alu_core
  import alu_pkg::*;
(
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  output logic              o_illegal
);
  always_comb begin
    o_result = '0;
    o_illegal = 1'b0;
    case (i_op)
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_SLT: o_result = {{(DATA_W-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      ALU_XOR: o_result = i_a ^ i_b;
      default: o_illegal = 1'b1;
    endcase
  end
  assign o_zero = o_result == '0;
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU stage with a 2-entry FIFO output buffer (head/tail) under an entry-count FSM.
module alu_exec_stage
  import alu_pkg::*;
(
  input logic clk,
  input logic rst_n,
  input logic flush,
  alu_exec_stage_if.slave bus
);
  state_t r_state, w_next;
  entry_t r_head, r_tail, w_head, w_tail, w_new;
  logic w_push, w_pop;
  alu_core u_core (
    .i_op(bus.in_op),
    .i_a(bus.in_a),
    .i_b(bus.in_b),
    .o_result(w_new.result),
    .o_zero(w_new.zero),
    .o_illegal(w_new.illegal)
  );
  assign w_new.tag = bus.in_tag;
  assign w_push = bus.in_valid && r_state != TWO;
  assign w_pop = r_state != EMPTY && bus.out_ready;
  always_comb begin
    w_next = r_state;
    w_head = r_head;
    w_tail = r_tail;
    if (flush) w_next = EMPTY;
    else
      case (r_state)
        EMPTY: if (w_push) begin w_next = ONE; w_head = w_new; end
        ONE:
          if (w_push && w_pop) w_head = w_new;
          else if (w_push) begin w_next = TWO; w_tail = w_new; end
          else if (w_pop) w_next = EMPTY;
        TWO: if (w_pop) begin w_next = ONE; w_head = r_tail; end
        default: w_next = EMPTY;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= EMPTY;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      r_state <= w_next;
      r_head <= w_head;
      r_tail <= w_tail;
    end
  // Handshake outputs come straight from the state flops, never from out_ready
  assign bus.in_ready = r_state != TWO;
  assign bus.out_valid = r_state != EMPTY;
  assign bus.out_result = r_head.result;
  assign bus.out_zero = r_head.zero;
  assign bus.out_illegal = r_head.illegal;
  assign bus.out_tag = r_head.tag;
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: table-driven vectors plus stall/flush/reset sequences, checked through an output scoreboard.
module tb_alu_exec_stage;
  import alu_pkg::*;
  typedef struct packed {
    logic [31:0] r;
    logic z;
    logic i;
    logic [4:0] t;
  } exp_t;
  typedef struct packed {
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0] tag;
    exp_t e;
  } vec_t;
  logic clk, rst_n, flush;
  int errs = 0;
  int checks = 0;
  exp_t q[$];
  exp_t m_e;
  vec_t vecs[12];
  alu_exec_stage_if bus();
  alu_exec_stage dut (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (rst_n && !flush && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_out: got result %h tag %0d expected nothing", bus.out_result, bus.out_tag);
      end else begin
        m_e = q.pop_front();
        chk("out_result", bus.out_result, m_e.r);
        chk("out_zero", {31'b0, bus.out_zero}, {31'b0, m_e.z});
        chk("out_illegal", {31'b0, bus.out_illegal}, {31'b0, m_e.i});
        chk("out_tag", {27'b0, bus.out_tag}, {27'b0, m_e.t});
      end
    end
  task automatic send(input vec_t v, output int waits);
    logic acc;
    acc = 1'b0;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_op = v.op;
    bus.in_a = v.a;
    bus.in_b = v.b;
    bus.in_tag = v.tag;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) q.push_back(v.e);
      @(posedge clk);
      #1;
      if (!acc) waits++;
    end
    if (!acc) begin
      checks++;
      errs++;
      $display("FAIL send_timeout: got no accept expected accept tag %0d", v.tag);
    end
    bus.in_valid = 1'b0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    chk({tag, "_out_result"}, bus.out_result, 32'd0);
    chk({tag, "_out_zero"}, {31'b0, bus.out_zero}, 32'd0);
    chk({tag, "_out_illegal"}, {31'b0, bus.out_illegal}, 32'd0);
    chk({tag, "_out_tag"}, {27'b0, bus.out_tag}, 32'd0);
  endtask
  initial begin
    int w;
    vec_t v;
    vecs[0]  = '{ALU_ADD, 32'h7FFFFFFF, 32'h1,        5'd1,  '{32'h80000000, 1'b0, 1'b0, 5'd1}};
    vecs[1]  = '{ALU_SUB, 32'd5,        32'd5,        5'd2,  '{32'h0,        1'b1, 1'b0, 5'd2}};
    vecs[2]  = '{ALU_SLT, 32'hFFFFFFFF, 32'h1,        5'd3,  '{32'h1,        1'b0, 1'b0, 5'd3}};
    vecs[3]  = '{4'b1010, 32'd3,        32'd4,        5'd4,  '{32'h0,        1'b1, 1'b1, 5'd4}};
    vecs[4]  = '{ALU_AND, 32'hF0F0F0F0, 32'hFF00FF00, 5'd5,  '{32'hF000F000, 1'b0, 1'b0, 5'd5}};
    vecs[5]  = '{ALU_OR,  32'h0F0F0000, 32'h000000F0, 5'd6,  '{32'h0F0F00F0, 1'b0, 1'b0, 5'd6}};
    vecs[6]  = '{ALU_XOR, 32'hAAAAAAAA, 32'hAAAAAAAA, 5'd7,  '{32'h0,        1'b1, 1'b0, 5'd7}};
    vecs[7]  = '{ALU_SUB, 32'd0,        32'd1,        5'd8,  '{32'hFFFFFFFF, 1'b0, 1'b0, 5'd8}};
    vecs[8]  = '{ALU_SLT, 32'd1,        32'hFFFFFFFF, 5'd9,  '{32'h0,        1'b1, 1'b0, 5'd9}};
    vecs[9]  = '{ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 5'd10, '{32'h1,        1'b0, 1'b0, 5'd10}};
    vecs[10] = '{4'b1111, 32'd1,        32'd1,        5'd11, '{32'h0,        1'b1, 1'b1, 5'd11}};
    vecs[11] = '{ALU_ADD, 32'hFFFFFFFF, 32'h1,        5'd12, '{32'h0,        1'b1, 1'b0, 5'd12}};
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = '0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    #2;
    chk_reset_outs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) begin
      send(vecs[i], w);
      chk("no_stall", w, 0);
      if (i == 0) chk("latency_valid", {31'b0, bus.out_valid}, 32'd1);
    end
    drain();
    // Back-pressure: two beats fill the buffer, third must wait
    bus.out_ready = 1'b0;
    send('{ALU_ADD, 32'd10, 32'd20, 5'd13, '{32'd30, 1'b0, 1'b0, 5'd13}}, w);
    send('{ALU_XOR, 32'hFF, 32'h0F, 5'd14, '{32'hF0, 1'b0, 1'b0, 5'd14}}, w);
    bus.in_valid = 1'b1;
    bus.in_op = ALU_OR;
    bus.in_a = 32'd1;
    bus.in_b = 32'd2;
    bus.in_tag = 5'd15;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("stall_result", bus.out_result, 32'd30);
      chk("stall_tag", {27'b0, bus.out_tag}, 32'd13);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send('{ALU_OR, 32'd1, 32'd2, 5'd15, '{32'd3, 1'b0, 1'b0, 5'd15}}, w);
    drain();
    // Flush from TWO with a live input beat
    bus.out_ready = 1'b0;
    send('{ALU_ADD, 32'd7, 32'd8, 5'd16, '{32'd15, 1'b0, 1'b0, 5'd16}}, w);
    send('{ALU_ADD, 32'd9, 32'd9, 5'd17, '{32'd18, 1'b0, 1'b0, 5'd17}}, w);
    q.delete();
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_op = ALU_ADD;
    bus.in_a = 32'd100;
    bus.in_b = 32'd1;
    bus.in_tag = 5'd18;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    send('{ALU_SUB, 32'd50, 32'd8, 5'd19, '{32'd42, 1'b0, 1'b0, 5'd19}}, w);
    drain();
    repeat (3) @(posedge clk);
    #1;
    // Async reset while stalled with two entries
    bus.out_ready = 1'b0;
    send('{ALU_XOR, 32'h1234, 32'h1, 5'd20, '{32'h1235, 1'b0, 1'b0, 5'd20}}, w);
    send('{ALU_AND, 32'hFFFF, 32'h00F0, 5'd21, '{32'hF0, 1'b0, 1'b0, 5'd21}}, w);
    chk("pre_reset_full", {31'b0, bus.in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_out_valid", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk_reset_outs("post_reset");
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send('{ALU_ADD, 32'd1, 32'd1, 5'd22, '{32'd2, 1'b0, 1'b0, 5'd22}}, w);
    drain();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
